// File: rtl/ioctl_loader_pkg.sv
// rtl/ioctl_loader_pkg.sv - shared types and constants for the ioctl download engine
//
// Contents:
//   IOCTL_DATA_W          width of one ioctl / RAM data word
//   IOCTL_ADDR_W          width of the address field carried through the write buffer
//   ioctl_loader_state_t  engine states IDLE / LOAD / DRAIN
//   ram_wr_t              one buffered RAM write {addr, data}
package ioctl_loader_pkg;

    localparam int IOCTL_DATA_W = 16;
    localparam int IOCTL_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } ioctl_loader_state_t;

    typedef struct packed {
        logic [IOCTL_ADDR_W-1:0] addr;
        logic [IOCTL_DATA_W-1:0] data;
    } ram_wr_t;

endpackage

// File: rtl/ioctl_loader_fifo.sv
// rtl/ioctl_loader_fifo.sv - synchronous write buffer of ram_wr_t entries
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears pointers and count
//   push   in   write wdata (ignored when full)
//   pop    in   discard head entry (ignored when empty)
//   wdata  in   entry to write
//   rdata  out  head entry (valid when !empty)
//   count  out  number of stored entries
//   full   out  count == DEPTH
//   empty  out  count == 0
module ioctl_loader_fifo
    import ioctl_loader_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  ram_wr_t       wdata,
    output ram_wr_t       rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    ram_wr_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ioctl_loader.sv
// rtl/ioctl_loader.sv - turns ioctl download writes into buffered RAM write requests
//
// Optional feature macro: IOCTL_LOADER_CHECKSUM_EN (16-bit running sum of pushed words).
//
// Ports:
//   clk_sys         in   system clock
//   reset           in   asynchronous active-high reset
//   ioctl_download  in   download-in-progress level
//   ioctl_index     in   region select, bits [5:0] used
//   ioctl_wr        in   one-cycle write strobe
//   ioctl_addr      in   byte offset within the download
//   ioctl_dout      in   write data
//   ioctl_wait      out  back-pressure to the HPS
//   ram_req         out  RAM write request level (buffer not empty)
//   ram_addr        out  RAM byte address of the head entry
//   ram_din         out  RAM data of the head entry
//   ram_ack         in   head entry accepted by RAM
//   busy            out  engine in LOAD or DRAIN
//   done            out  one-cycle pulse when a download is fully committed
//   err_range       out  sticky: a write beyond the region size was dropped
//   err_ovf         out  sticky: a write hit a full buffer and was dropped
//   checksum        out  sum of pushed words (0 when the feature is not built)
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 25,
    parameter int FIFO_DEPTH  = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_SIZE = '1,
    parameter logic [NUM_REGIONS-1:0]             REGION_SWAP = '1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [IOCTL_DATA_W-1:0] ioctl_dout,
    output logic                    ioctl_wait,
    output logic                    ram_req,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [IOCTL_DATA_W-1:0] ram_din,
    input  logic                    ram_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    err_range,
    output logic                    err_ovf,
    output logic [IOCTL_DATA_W-1:0] checksum
);

    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ioctl_loader_state_t state;
    logic [RW-1:0]       region;
    logic                dl_prev;
    logic                pending;

    logic                dl_rise;
    logic                idx_ok;
    logic                start;
    logic                accept;
    logic                in_range;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   wr_addr;
    logic [IOCTL_DATA_W-1:0] wr_data;
    ram_wr_t             fifo_in;
    ram_wr_t             fifo_head;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic                full;
    logic                empty;
    logic                wait_lvl;
    logic                unused_bits;

    assign unused_bits = ^ioctl_index[7:6];

    assign dl_rise = ioctl_download && !dl_prev;
    assign idx_ok  = 32'(ioctl_index[5:0]) < NUM_REGIONS;
    // A rise seen during DRAIN is remembered and taken as soon as IDLE is
    // reached, provided the download level is still high.
    assign start   = (state == IDLE) && ioctl_download && (dl_rise || pending) && idx_ok;

    assign accept   = (state == LOAD) && ioctl_wr;
    assign in_range = ioctl_addr < 25'(REGION_SIZE[region]);
    assign push     = accept && in_range && !full;
    assign pop      = ram_ack && !empty;
    assign wr_addr  = REGION_BASE[region] + ADDR_W'(ioctl_addr);
    assign wr_data  = REGION_SWAP[region] ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;

    always_comb begin
        fifo_in      = '0;
        fifo_in.addr = IOCTL_ADDR_W'(wr_addr);
        fifo_in.data = wr_data;
    end

    // Back-pressure is computed from the post-edge occupancy so the flag is a
    // plain register with no path from ioctl_wr to ioctl_wait.
    assign count_next = count + CW'(push) - CW'(pop);
    assign wait_lvl   = count_next >= CW'(FIFO_DEPTH - 1);

    ioctl_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_in),
        .rdata (fifo_head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ram_req  = !empty;
    assign ram_addr = ADDR_W'(fifo_head.addr);
    assign ram_din  = fifo_head.data;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            region     <= '0;
            dl_prev    <= 1'b0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ioctl_wait <= 1'b0;
            err_range  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            dl_prev    <= ioctl_download;
            done       <= 1'b0;
            ioctl_wait <= wait_lvl;
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (start) begin
                        state     <= LOAD;
                        region    <= RW'(ioctl_index[5:0]);
                        busy      <= 1'b1;
                        err_range <= 1'b0;
                        err_ovf   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept && !in_range) begin
                        err_range <= 1'b1;
                    end else if (accept && full) begin
                        err_ovf <= 1'b1;
                    end
                    if (!ioctl_download) begin
                        state      <= DRAIN;
                        ioctl_wait <= 1'b1;
                    end
                end
                DRAIN: begin
                    ioctl_wait <= 1'b1;
                    if (dl_rise) begin
                        pending <= 1'b1;
                    end
                    if (empty) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        ioctl_wait <= wait_lvl;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum + wr_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// tb/tb_ioctl_loader.sv - self-checking bench for ioctl_loader
module tb_ioctl_loader;

    localparam int NR = 4;
    localparam int AW = 25;
    localparam int FD = 4;
    localparam logic [NR-1:0][AW-1:0] P_BASE = {25'h1FFFFFC, 25'h0100000, 25'h0000200, 25'h0000000};
    localparam logic [NR-1:0][AW-1:0] P_SIZE = {25'h1FFFFFF, 25'h0000004, 25'h0001000, 25'h1FFFFFF};
    localparam logic [NR-1:0]         P_SWAP = 4'b1001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        ram_req;
    logic [AW-1:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err_range;
    logic        err_ovf;
    logic [15:0] checksum;

    ioctl_loader #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .FIFO_DEPTH  (FD),
        .REGION_BASE (P_BASE),
        .REGION_SIZE (P_SIZE),
        .REGION_SWAP (P_SWAP)
    ) dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_req        (ram_req),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_ack        (ram_ack),
        .busy           (busy),
        .done           (done),
        .err_range      (err_range),
        .err_ovf        (err_ovf),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int          idx;
        logic [24:0] a;
        logic [15:0] d;
        bit          valid;
        logic [24:0] ea;
        logic [15:0] ed;
    } vec_t;

    wr_t   got[$];
    wr_t   expq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    done_cnt = 0;
    int    req_cnt = 0;
    int    ack_mode = 0;
    int    d0;
    logic [15:0] exp_sum;
    bit    exp_err;

    // RAM side: decide the ack at the falling edge, log the word being acked.
    always @(negedge clk) begin
        if (ram_req && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(1, 0) == 1))) begin
            ram_ack = 1'b1;
            got.push_back('{a: ram_addr, d: ram_din});
        end else begin
            ram_ack = 1'b0;
        end
        if (done) done_cnt++;
        if (ram_req) req_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk({tag, "_addr"}, 32'(got[i].a), 32'(expq[i].a));
            chk({tag, "_data"}, 32'(got[i].d), 32'(expq[i].d));
        end
    endtask

    task automatic model_wr(input int r, input logic [24:0] a, input logic [15:0] d);
        wr_t e;
        if (a < P_SIZE[r]) begin
            e.a = P_BASE[r] + a;
            e.d = P_SWAP[r] ? {d[7:0], d[15:8]} : d;
            expq.push_back(e);
            exp_sum = exp_sum + e.d;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic do_wr(input logic [24:0] a, input logic [15:0] d, input bit honour);
        int g = 0;
        while (honour && ioctl_wait && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("wait_timeout", 32'(g), 32'd0);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic begin_dl(input int idx);
        got.delete();
        expq.delete();
        exp_sum = '0;
        exp_err = 1'b0;
        d0 = done_cnt;
        ioctl_index = 8'(idx);
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_wait();
        int g = 0;
        while ((busy || ram_req) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) chk("drain_timeout", 32'(g), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [15:0] exp_ck();
`ifdef IOCTL_LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 16'h0000;
`endif
    endfunction

    initial begin
        vec_t tbl[6];
        int   rq0;
        int   bz;

        tbl[0] = '{0, 25'h0000000, 16'h1234, 1'b1, 25'h0000000, 16'h3412};
        tbl[1] = '{1, 25'h0000010, 16'hABCD, 1'b1, 25'h0000210, 16'hABCD};
        tbl[2] = '{2, 25'h0000002, 16'h5555, 1'b1, 25'h0100002, 16'h5555};
        tbl[3] = '{2, 25'h0000004, 16'h6666, 1'b0, 25'h0000000, 16'h0000};
        tbl[4] = '{3, 25'h0000006, 16'h0102, 1'b1, 25'h0000002, 16'h0201};
        tbl[5] = '{3, 25'h0000000, 16'hFF00, 1'b1, 25'h1FFFFFC, 16'h00FF};

        // Reset state
        @(negedge clk);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_req", 32'(ram_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_erange", 32'(err_range), 0);
        chk("rst_eovf", 32'(err_ovf), 0);
        chk("rst_cksum", 32'(checksum), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table: one single-write download per entry
        ack_mode = 1;
        for (int i = 0; i < 6; i++) begin
            begin_dl(tbl[i].idx);
            do_wr(tbl[i].a, tbl[i].d, 1'b1);
            end_dl();
            drain_wait();
            chk("tbl_count", got.size(), 32'(tbl[i].valid));
            if (got.size() > 0 && tbl[i].valid) begin
                chk("tbl_addr", 32'(got[0].a), 32'(tbl[i].ea));
                chk("tbl_data", 32'(got[0].d), 32'(tbl[i].ed));
            end
            chk("tbl_erange", 32'(err_range), 32'(!tbl[i].valid));
            chk("tbl_done", done_cnt - d0, 1);
        end

        // Region 0, four swapped words
        begin_dl(0);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] dv;
            case (i)
                0: dv = 16'h1234;
                1: dv = 16'h5678;
                2: dv = 16'h9ABC;
                default: dv = 16'hDEF0;
            endcase
            model_wr(0, 25'(2 * i), dv);
            do_wr(25'(2 * i), dv, 1'b1);
        end
        end_dl();
        drain_wait();
        chk_log("r0_seq");
        chk("r0_done", done_cnt - d0, 1);
        chk("r0_cksum", 32'(checksum), 32'(exp_ck()));

        // Region 2, third write out of range
        begin_dl(2);
        for (int i = 0; i < 3; i++) begin
            model_wr(2, 25'(2 * i), 16'(16'hA000 + i));
            do_wr(25'(2 * i), 16'(16'hA000 + i), 1'b1);
        end
        end_dl();
        drain_wait();
        chk_log("r2_seq");
        chk("r2_erange", 32'(err_range), 1);
        chk("r2_eovf", 32'(err_ovf), 0);

        // Back-pressure with RAM stalled
        ack_mode = 0;
        begin_dl(1);
        for (int i = 0; i < 2; i++) begin
            model_wr(1, 25'(2 * i), 16'(16'h1100 + i));
            do_wr(25'(2 * i), 16'(16'h1100 + i), 1'b1);
        end
        chk("bp_wait_two", 32'(ioctl_wait), 0);
        model_wr(1, 25'd4, 16'h1102);
        do_wr(25'd4, 16'h1102, 1'b1);
        chk("bp_wait_three", 32'(ioctl_wait), 1);
        repeat (20) @(negedge clk);
        chk("bp_wait_hold", 32'(ioctl_wait), 1);
        chk("bp_no_ram", got.size(), 0);
        ack_mode = 1;
        for (int i = 3; i < 6; i++) begin
            model_wr(1, 25'(2 * i), 16'(16'h1100 + i));
            do_wr(25'(2 * i), 16'(16'h1100 + i), 1'b1);
        end
        end_dl();
        drain_wait();
        chk_log("bp_seq");
        chk("bp_eovf", 32'(err_ovf), 0);

        // Overflow: wait ignored, no ack
        ack_mode = 0;
        begin_dl(1);
        for (int i = 0; i < 6; i++) begin
            if (i < FD) model_wr(1, 25'(2 * i), 16'(16'h2200 + i));
            do_wr(25'(2 * i), 16'(16'h2200 + i), 1'b0);
        end
        end_dl();
        chk("ovf_eovf", 32'(err_ovf), 1);
        chk("ovf_erange", 32'(err_range), 0);
        ack_mode = 1;
        drain_wait();
        chk_log("ovf_seq");
        chk("ovf_cksum", 32'(checksum), 32'(exp_ck()));

        // Invalid index
        rq0 = req_cnt;
        bz = 0;
        begin_dl(9);
        do_wr(25'd0, 16'h7777, 1'b0);
        do_wr(25'd2, 16'h8888, 1'b0);
        end_dl();
        repeat (8) begin
            if (busy) bz++;
            @(negedge clk);
        end
        chk("inv_busy", bz, 0);
        chk("inv_req", req_cnt - rq0, 0);
        chk("inv_done", done_cnt - d0, 0);
        chk("inv_ram", got.size(), 0);

        // Reset with two entries queued
        ack_mode = 0;
        begin_dl(0);
        do_wr(25'd0, 16'h4321, 1'b1);
        do_wr(25'd2, 16'h8765, 1'b1);
        chk("rstq_req_before", 32'(ram_req), 1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        chk("rstq_req", 32'(ram_req), 0);
        chk("rstq_busy", 32'(busy), 0);
        chk("rstq_wait", 32'(ioctl_wait), 0);
        rq0 = req_cnt;
        @(negedge clk);
        reset = 1'b0;
        ack_mode = 1;
        got.delete();
        repeat (10) @(negedge clk);
        chk("rstq_after_req", req_cnt - rq0, 0);
        chk("rstq_after_ram", got.size(), 0);

        // Randomised downloads against the model
        for (int k = 0; k < 40; k++) begin
            int r;
            int n;
            r = $urandom_range(NR - 1, 0);
            n = $urandom_range(6, 1);
            ack_mode = 2;
            begin_dl(r);
            for (int j = 0; j < n; j++) begin
                logic [24:0] a;
                logic [15:0] dv;
                a = (r == 2) ? 25'(2 * $urandom_range(4, 0)) : 25'(2 * $urandom_range(64, 0));
                dv = 16'($urandom);
                model_wr(r, a, dv);
                do_wr(a, dv, 1'b1);
                if ($urandom_range(3, 0) == 0) @(negedge clk);
            end
            end_dl();
            drain_wait();
            chk_log("rnd_seq");
            chk("rnd_erange", 32'(err_range), 32'(exp_err));
            chk("rnd_eovf", 32'(err_ovf), 0);
            chk("rnd_cksum", 32'(checksum), 32'(exp_ck()));
            chk("rnd_done", done_cnt - d0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
